// File: rtl/sockit_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sockit_input_conditioner                                       |
// | Purpose : synchronise/debounce SW and KEY, make press pulses and a       |
// |           stretched active-low core reset from pushbutton 0.             |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sockit_input_conditioner #(
  parameter int N_SW      = 18,
  parameter int N_PB      = 4,
  parameter int DB_CYCLES = 500000,
  parameter int RST_HOLD  = 1024,
  parameter int CNT_W     = 20
) (
  input  logic            CLOCK_50,
  input  logic            RESET,
  input  logic [N_SW-1:0] SW,
  input  logic [N_PB-1:0] KEY,
  output logic [N_SW-1:0] SW_DB,
  output logic [N_PB-1:0] PB_DB,
  output logic [N_PB-1:0] PB_PRESS,
  output logic            CORE_RESET_N
);

  localparam int              N_ALL     = N_SW + N_PB;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [0:0] ST_HOLD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (DB_CYCLES < 2 || RST_HOLD < 1 ||
      CNT_W < $clog2(DB_CYCLES) || CNT_W < $clog2(RST_HOLD)) begin : g_cnt_w_check
    $error("sockit_input_conditioner: CNT_W too small or DB_CYCLES/RST_HOLD out of range");
  end

  logic [N_SW-1:0]  sw_s1_q, sw_s2_q;
  logic [N_PB-1:0]  key_s1_q, key_s2_q;
  logic [N_ALL-1:0] synced;
  logic [N_ALL-1:0] db_q, db_d;
  logic [CNT_W-1:0] cnt_q [N_ALL];
  logic [CNT_W-1:0] cnt_d [N_ALL];
  logic [N_PB-1:0]  press_q, press_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             core_reset_n;

  // Buttons become active-high only after the synchroniser.
  assign synced = {~key_s2_q, sw_s2_q};

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < N_ALL; i++) begin
      cnt_d[i] = '0;
      if (synced[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) db_d[i] = synced[i];
        else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    press_d = db_d[N_ALL-1:N_SW] & ~db_q[N_ALL-1:N_SW];
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      ST_HOLD: begin
        if (db_q[N_SW])               hcnt_d  = '0;
        else if (hcnt_q == HOLD_LAST) state_d = ST_RUN;
        else                          hcnt_d  = hcnt_q + CNT_ONE;
      end
      default: begin
        if (db_q[N_SW]) begin
          state_d = ST_HOLD;
          hcnt_d  = '0;
        end
      end
    endcase
  end

  always_comb begin
    core_reset_n = (state_q == ST_RUN);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= '1;
      key_s2_q <= '1;
      db_q     <= '0;
      press_q  <= '0;
      for (int i = 0; i < N_ALL; i++) cnt_q[i] <= '0;
      state_q  <= ST_HOLD;
      hcnt_q   <= '0;
    end else begin
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= KEY;
      key_s2_q <= key_s1_q;
      db_q     <= db_d;
      press_q  <= press_d;
      for (int i = 0; i < N_ALL; i++) cnt_q[i] <= cnt_d[i];
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
    end
  end

  assign SW_DB        = db_q[N_SW-1:0];
  assign PB_DB        = db_q[N_ALL-1:N_SW];
  assign PB_PRESS     = press_q;
  assign CORE_RESET_N = core_reset_n;

endmodule
`default_nettype wire

// File: tb/tb_sockit_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sockit_input_conditioner                                    |
// | Purpose : scoreboard bench for sockit_input_conditioner                  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_sockit_input_conditioner;

  localparam int N_SW  = 4;
  localparam int N_PB  = 4;
  localparam int DB    = 8;
  localparam int HOLD  = 4;
  localparam int CNT_W = 20;
  localparam int NA    = N_SW + N_PB;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_SW-1:0] sw;
  logic [N_PB-1:0] key;
  logic [N_SW-1:0] sw_db;
  logic [N_PB-1:0] pb_db;
  logic [N_PB-1:0] pb_press;
  logic            core_rstn;

  always #5 clk = ~clk;

  sockit_input_conditioner #(
    .N_SW(N_SW), .N_PB(N_PB), .DB_CYCLES(DB), .RST_HOLD(HOLD), .CNT_W(CNT_W)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .SW(sw), .KEY(key),
    .SW_DB(sw_db), .PB_DB(pb_db), .PB_PRESS(pb_press), .CORE_RESET_N(core_rstn)
  );

  typedef struct packed {
    logic [N_SW-1:0] sw_db;
    logic [N_PB-1:0] pb_db;
    logic [N_PB-1:0] press;
    logic            rstn;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp, mon_act;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model: pin history, run lengths of disagreement, quiet time in hold.
  logic [N_SW-1:0] m_sw1, m_sw2;
  logic [N_PB-1:0] m_key1, m_key2;
  logic [NA-1:0]   m_stable;
  int              m_run [NA];
  logic [N_PB-1:0] m_press;
  bit              m_hold;
  int              m_quiet;

  task automatic model_reset();
    m_sw1 = '0; m_sw2 = '0; m_key1 = '1; m_key2 = '1;
    m_stable = '0; m_press = '0; m_hold = 1'b1; m_quiet = 0;
    for (int i = 0; i < NA; i++) m_run[i] = 0;
  endtask

  task automatic model_step(input bit r, input logic [N_SW-1:0] s, input logic [N_PB-1:0] k);
    logic [NA-1:0] syn, nxt;
    bit            pb0_was;
    if (r) begin
      model_reset();
    end else begin
      syn = {~m_key2, m_sw2};
      nxt = m_stable;
      for (int i = 0; i < NA; i++) begin
        if (syn[i] !== m_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB) begin
            nxt[i]   = syn[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      pb0_was  = m_stable[N_SW];
      m_press  = nxt[NA-1:N_SW] & ~m_stable[NA-1:N_SW];
      m_stable = nxt;
      if (m_hold) begin
        if (pb0_was) m_quiet = 0;
        else begin
          m_quiet = m_quiet + 1;
          if (m_quiet == HOLD) m_hold = 1'b0;
        end
      end else if (pb0_was) begin
        m_hold  = 1'b1;
        m_quiet = 0;
      end
      m_sw2 = m_sw1; m_sw1 = s; m_key2 = m_key1; m_key1 = k;
    end
  endtask

  logic [N_SW-1:0] cur_sw;
  logic [N_PB-1:0] cur_key;

  task automatic apply(input bit r);
    exp_t e;
    @(negedge clk);
    rst = r; sw = cur_sw; key = cur_key;
    model_step(r, cur_sw, cur_key);
    e.sw_db = m_stable[N_SW-1:0];
    e.pb_db = m_stable[NA-1:N_SW];
    e.press = m_press;
    e.rstn  = ~m_hold;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) apply(1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = '{sw_db: sw_db, pb_db: pb_db, press: pb_press, rstn: core_rstn};
      vectors++;
      if (mon_act !== mon_exp) begin
        miscompares++;
        $display("FAIL outputs t=%0t: got sw_db=%h pb_db=%h press=%h rstn=%b, required sw_db=%h pb_db=%h press=%h rstn=%b",
                 $time, mon_act.sw_db, mon_act.pb_db, mon_act.press, mon_act.rstn,
                 mon_exp.sw_db, mon_exp.pb_db, mon_exp.press, mon_exp.rstn);
      end
    end
  end

  int first_k;

  initial begin
    rst = 1'b1; sw = '0; key = '1;
    cur_sw = '0; cur_key = '1;
    model_reset();

    apply(1'b1);
    run(8);

    // Clean switch edge: independent latency check on top of the scoreboard.
    cur_sw[2] = 1'b1;
    apply(1'b0);
    first_k = -1;
    for (int k = 1; k <= 16; k++) begin
      apply(1'b0);
      if (sw_db[2] && first_k < 0) first_k = k;
    end
    vectors++;
    if (first_k != DB + 2) begin
      miscompares++;
      $display("FAIL sw_latency: got %0d cycles, required %0d", first_k, DB + 2);
    end

    // Bouncing button 1
    cur_key[1] = 1'b0; run(5);
    cur_key[1] = 1'b1; run(1);
    cur_key[1] = 1'b0; run(20);
    cur_key[1] = 1'b1; run(15);

    // Core reset from button 0 while running
    cur_key[0] = 1'b0; run(12);
    cur_key[0] = 1'b1; run(20);

    // Re-press during the hold window
    cur_key[0] = 1'b0; run(12);
    cur_key[0] = 1'b1; run(12);
    cur_key[0] = 1'b0; run(12);
    cur_key[0] = 1'b1; run(20);

    // Reset in the middle of a switch debounce
    cur_sw[0] = 1'b1; run(5);
    apply(1'b1);
    run(16);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_SW; i++)
        if ($urandom_range(0, 15) == 0) cur_sw[i] = ~cur_sw[i];
      for (int i = 1; i < N_PB; i++)
        if ($urandom_range(0, 11) == 0) cur_key[i] = ~cur_key[i];
      if ($urandom_range(0, 39) == 0) cur_key[0] = ~cur_key[0];
      apply($urandom_range(0, 299) == 0);
    end

    cur_key = '1;
    run(20);
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
